// File: rtl/pipe_cpu.sv
`timescale 1ns/1ps
// Single-issue CPU execute stage: three-register instructions over a flop register file,
// one-cycle logic/arithmetic ops and bit-serial shifts, with result forwarding into the next issue.
module pipe_cpu #(
    parameter int d_width   = 32,
    parameter int reg_ct    = 32,
    parameter int ra_width  = $clog2(reg_ct),
    parameter int ins_width = 3 + 3 * ra_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ins_width-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic                 wb_valid,
    output logic [ra_width-1:0]  wb_addr,
    output logic [d_width-1:0]   wb_data,
    input  logic [ra_width-1:0]  dbg_addr,
    output logic [d_width-1:0]   dbg_data
);
    localparam int sh_width = $clog2(d_width + 1);

    typedef enum logic [1:0] {IDLE, ALU, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [ra_width-1:0]  rd_q, rd_d;
    logic [d_width-1:0]   a_q, a_d;
    logic [d_width-1:0]   b_q, b_d;
    logic [sh_width-1:0]  rem_q, rem_d;
    logic [d_width-1:0]   regs_q [reg_ct];
    logic                 wb_valid_q;
    logic [ra_width-1:0]  wb_addr_q;
    logic [d_width-1:0]   wb_data_q;

    logic [2:0]           ins_op;
    logic [ra_width-1:0]  ins_rd, ins_rs1, ins_rs2;
    logic [d_width-1:0]   alu_res, shift_step, result, op1, op2;
    logic [sh_width-1:0]  sh_clip;
    logic                 done, accept;

    assign ins_op  = ins[ins_width-1 -: 3];
    assign ins_rd  = ins[3*ra_width-1 -: ra_width];
    assign ins_rs1 = ins[2*ra_width-1 -: ra_width];
    assign ins_rs2 = ins[ra_width-1:0];

    always_comb begin
        unique case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q & b_q;
            3'b010:  alu_res = ~(a_q & b_q);
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = {{(d_width-1){1'b0}}, (a_q > b_q)};
            default: alu_res = '0;
        endcase
    end

    // rem_q counts shift steps still to apply; zero means a zero-length shift (pass-through).
    assign shift_step = (rem_q != '0) ? (op_q[0] ? (a_q >> 1) : (a_q << 1)) : a_q;
    assign result     = (state_q == SHIFT) ? shift_step : alu_res;
    assign done       = (state_q == ALU) || ((state_q == SHIFT) && (rem_q <= sh_width'(1)));
    assign ins_ready  = !rst && ((state_q == IDLE) || done);
    assign accept     = ins_valid && ins_ready;

    // Operands see the result retiring on the same edge.
    assign op1 = (done && (rd_q == ins_rs1)) ? result : regs_q[ins_rs1];
    assign op2 = (done && (rd_q == ins_rs2)) ? result : regs_q[ins_rs2];

    always_comb begin
        if (32'(ins_rs2) >= 32'(d_width)) sh_clip = sh_width'(d_width);
        else                               sh_clip = sh_width'(ins_rs2);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        if ((state_q == SHIFT) && !done) begin
            a_d   = shift_step;
            rem_d = rem_q - sh_width'(1);
        end
        if (done) state_d = IDLE;
        if (accept) begin
            op_d    = ins_op;
            rd_d    = ins_rd;
            a_d     = op1;
            b_d     = op2;
            rem_d   = sh_clip;
            state_d = (ins_op[2:1] == 2'b11) ? SHIFT : ALU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < reg_ct; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            wb_valid_q <= done;
            if (done) begin
                regs_q[rd_q] <= result;
                wb_addr_q    <= rd_q;
                wb_data_q    <= result;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_pipe_cpu.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for pipe_cpu: an architectural register model predicts each
// writeback (address, data, completion cycle); a monitor pops and compares on every wb_valid.
module tb_pipe_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    localparam logic [2:0] OP_ADD = 3'd0, OP_AND = 3'd1, OP_NAND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_SGT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

    pipe_cpu dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t        q[$];
    logic [31:0] model [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int sh);
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_NAND: return ~(a & b);
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SGT:  return (a > b) ? 32'd1 : 32'd0;
            OP_SLL:  return (sh >= 32) ? 32'd0 : (a << sh);
            default: return (sh >= 32) ? 32'd0 : (a >> sh);
        endcase
    endfunction

    // Monitor: every writeback must match the oldest outstanding prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && wb_valid) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wb: got wb to r%0d data 0x%08h expected none", wb_addr, wb_data);
            end else begin
                e = q.pop_front();
                check("wb_addr", 32'(wb_addr), 32'(e.a));
                check("wb_data", wb_data, e.d);
                check("wb_cycle", 32'(cyc), 32'(e.c));
                $display("wb r%0d = 0x%08h at cycle %0d", wb_addr, wb_data, cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit expect_wb = 1'b1);
        logic [31:0] res;
        int lat;
        int w;
        exp_t e;
        ins = {op, rd, rs1, rs2};
        ins_valid = 1'b1;
        w = 0;
        while (!ins_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ins_ready) begin
            checks++;
            $display("FAIL ready_timeout: got ins_ready=0 for 100 cycles expected 1");
            ins_valid = 1'b0;
            return;
        end
        res = ref_op(op, model[rs1], model[rs2], int'(rs2));
        lat = (op[2:1] == 2'b11) ? ((rs2 == 0) ? 1 : int'(rs2)) : 1;
        @(posedge clk);
        #1;
        if (expect_wb) begin
            model[rd] = res;
            e.a = rd; e.d = res; e.c = cyc + lat;
            q.push_back(e);
        end
        ins_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || !ins_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending writebacks expected 0", q.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_reg(input int idx);
        dbg_addr = 5'(idx);
        #1;
        check($sformatf("dbg_r%0d", idx), dbg_data, model[idx]);
    endtask

    // Builds a constant bit by bit using r31 == 1.
    task automatic load(input logic [4:0] rd, input logic [31:0] val);
        bit found;
        found = 1'b0;
        issue(OP_XOR, rd, rd, rd);
        for (int b = 31; b >= 0; b--) begin
            if (found) issue(OP_SLL, rd, rd, 5'd1);
            if (val[b]) begin
                issue(OP_OR, rd, rd, 5'd31);
                found = 1'b1;
            end
        end
    endtask

    task automatic setup_one();
        issue(OP_NAND, 5'd31, 5'd0, 5'd0);
        issue(OP_SGT, 5'd31, 5'd31, 5'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready_after"}, 32'(ins_ready), 32'd1);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        for (int i = 0; i < 32; i++) chk_reg(i);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [2:0] op;
        logic [4:0] rd, rs1, rs2;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        #12;
        check("rst_ready", 32'(ins_ready), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("reset");
        setup_one();

        // ADD into r0
        load(5'd1, 32'd5);
        load(5'd2, 32'd6);
        issue(OP_ADD, 5'd0, 5'd2, 5'd1);
        drain();
        chk_reg(0);
        check("add_r0_is_11", model[0], 32'd11);

        // Forwarding: XOR reads r5 on the edge ADD writes it
        issue(OP_ADD, 5'd5, 5'd1, 5'd2);
        issue(OP_XOR, 5'd6, 5'd5, 5'd1);
        drain();
        chk_reg(6);

        // Carry drop and unsigned compare back-to-back
        load(5'd1, 32'hFFFF_FFFF);
        load(5'd2, 32'd1);
        issue(OP_ADD, 5'd3, 5'd1, 5'd2);
        issue(OP_SGT, 5'd4, 5'd1, 5'd2);
        drain();
        chk_reg(3);
        chk_reg(4);

        // Shift timing: shamt 4 keeps ins_ready low three cycles
        load(5'd1, 32'd1);
        drain();
        issue(OP_SLL, 5'd7, 5'd1, 5'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sll4_ready_c%0d", k), 32'(ins_ready), 32'd0);
        end
        @(negedge clk);
        check("sll4_ready_last", 32'(ins_ready), 32'd1);
        drain();
        chk_reg(7);
        issue(OP_SLL, 5'd7, 5'd1, 5'd0);
        drain();
        chk_reg(7);

        // Reset mid-shift aborts with no writeback
        load(5'd1, 32'h8000_0000);
        drain();
        issue(OP_SRL, 5'd9, 5'd1, 5'd31, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ready_in_rst", 32'(ins_ready), 32'd0);
        check("abort_wb_in_rst", 32'(wb_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        check_cleared("abort");
        repeat (35) @(negedge clk);

        // NAND of zero, then idle cycles must produce no writeback
        issue(OP_NAND, 5'd8, 5'd1, 5'd1);
        drain();
        chk_reg(8);
        repeat (5) @(negedge clk);
        check("idle_ready", 32'(ins_ready), 32'd1);
        setup_one();

        // Random instruction stream with random issue gaps
        for (int n = 0; n < 150; n++) begin
            op  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 30));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            issue(op, rd, rs1, rs2);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        for (int i = 0; i < 32; i++) chk_reg(i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
